// File: rtl/adiabatic_pclk_gen_if.sv
// ---------------------------------------------------------------------------
// adiabatic_pclk_gen_if
// Bundles the run request and the four-phase power-clock rails of the
// adiabatic clock generator.
//   en       run request (level-sensitive), driven by the controller
//   lvl_pos  clkpos rail level per phase, phase i at [i*LW +: LW]
//   lvl_neg  clkneg rail level per phase (STEPS - lvl_pos)
//   clkpos   1-bit clkpos rail per phase (level above half swing)
//   clkneg   1-bit clkneg rail per phase (~clkpos)
//   sync     one-cycle pulse on the first cycle of each running period
//   busy     high while any phase is armed or the generator is running
// The master modport belongs to the generator; the slave modport belongs to
// the controller that raises en and consumes the rails.
// ---------------------------------------------------------------------------
interface adiabatic_pclk_gen_if #(
  parameter int LW = 3
);
  logic              en;
  logic [4*LW-1:0]   lvl_pos;
  logic [4*LW-1:0]   lvl_neg;
  logic [3:0]        clkpos;
  logic [3:0]        clkneg;
  logic              sync;
  logic              busy;

  modport master (
    input  en,
    output lvl_pos, lvl_neg, clkpos, clkneg, sync, busy
  );

  modport slave (
    output en,
    input  lvl_pos, lvl_neg, clkpos, clkneg, sync, busy
  );
endinterface

// File: rtl/adiabatic_pclk_gen.sv
// ---------------------------------------------------------------------------
// adiabatic_pclk_gen
// Digital model of a stepwise charger producing the four-phase trapezoidal
// power clocks for the MIPS25 adiabatic cells. Each phase ramps up over one
// interval, holds for one, ramps down for one and idles for one; phase i lags
// phase i-1 by one interval.
// Ports:
//   clk    system clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    adiabatic_pclk_gen_if.master: en in, rails/sync/busy out
// Parameters:
//   STEPS     levels per ramp (rail level spans 0..STEPS)
//   STEP_CYC  clock cycles spent on each level step (1..255)
// ---------------------------------------------------------------------------
module adiabatic_pclk_gen #(
  parameter int STEPS    = 4,
  parameter int STEP_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adiabatic_pclk_gen_if.master bus
);

  localparam int LW = $clog2(STEPS + 1);
  localparam int KW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int SW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;

  localparam logic [SW-1:0] S_LAST = SW'(STEP_CYC - 1);
  localparam logic [KW-1:0] K_LAST = KW'(STEPS - 1);
  localparam logic [LW-1:0] L_FULL = LW'(STEPS);
  localparam logic [LW-1:0] L_HALF = LW'(STEPS / 2);

  typedef enum logic [1:0] {
    ST_STOP,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t          r_state, w_stateNext;
  logic [SW-1:0]   r_s, w_sNext;
  logic [KW-1:0]   r_k, w_kNext;
  logic [1:0]      r_m, w_mNext;
  logic [3:0]      r_armed, w_armedNext;

  logic            w_sWrap, w_kWrap, w_periodEnd;
  logic [3:0]      w_lastDn, w_keep;

  logic [4*LW-1:0] r_lvlPos, r_lvlNeg, w_lvlPosNext, w_lvlNegNext;
  logic [3:0]      r_clkpos, w_clkposNext;
  logic            r_sync, r_busy, w_syncNext, w_busyNext;

  // Level of one phase from its interval code q and the step counter.
  // The DN ramp mirrors UP so consecutive levels never differ by more than 1.
  function automatic logic [LW-1:0] levelOf(input logic armed,
                                            input logic [1:0] q,
                                            input logic [KW-1:0] k);
    logic [LW-1:0] lv;
    lv = '0;
    if (armed) begin
      case (q)
        2'd0:    lv = LW'(int'(k) + 1);
        2'd1:    lv = L_FULL;
        2'd2:    lv = LW'(STEPS - 1 - int'(k));
        default: lv = '0;
      endcase
    end
    return lv;
  endfunction

  // Timebase, FSM and arming. Everything here is the value for the next
  // cycle, so the registered rails line up with the counters they describe.
  // A phase leaves the armed set once its last DN cycle (level 0) has been
  // shown; new phases are armed only when the next cycle is in RUN and starts
  // that phase's UP interval.
  always_comb begin
    w_sWrap     = (r_s == S_LAST);
    w_kWrap     = w_sWrap && (r_k == K_LAST);
    w_periodEnd = w_kWrap && (r_m == 2'd3);

    for (int i = 0; i < 4; i++) begin
      w_lastDn[i] = r_armed[i] && ((r_m - 2'(i)) == 2'd2) && w_kWrap;
    end
    w_keep = r_armed & ~w_lastDn;

    w_stateNext = r_state;
    w_sNext     = w_sWrap ? '0 : r_s + 1'b1;
    w_kNext     = w_sWrap ? ((r_k == K_LAST) ? '0 : r_k + 1'b1) : r_k;
    w_mNext     = w_kWrap ? r_m + 2'd1 : r_m;

    case (r_state)
      ST_STOP: begin
        w_sNext = '0;
        w_kNext = '0;
        w_mNext = '0;
        if (bus.en) w_stateNext = ST_RUN;
      end
      ST_RUN: begin
        if (w_periodEnd && !bus.en) w_stateNext = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_keep == 4'b0000) begin
          w_stateNext = ST_STOP;
          w_sNext     = '0;
          w_kNext     = '0;
          w_mNext     = '0;
        end
      end
      default: begin
        w_stateNext = ST_STOP;
        w_sNext     = '0;
        w_kNext     = '0;
        w_mNext     = '0;
      end
    endcase

    w_armedNext = w_keep;
    if (w_stateNext == ST_RUN && w_sNext == '0 && w_kNext == '0) begin
      for (int i = 0; i < 4; i++) begin
        if ((w_mNext - 2'(i)) == 2'd0) w_armedNext[i] = 1'b1;
      end
    end
  end

  // Rail values for the next cycle, derived from the next-cycle timebase.
  always_comb begin
    w_lvlPosNext = '0;
    w_lvlNegNext = '0;
    w_clkposNext = '0;
    for (int i = 0; i < 4; i++) begin
      w_lvlPosNext[i*LW +: LW] = levelOf(w_armedNext[i], w_mNext - 2'(i), w_kNext);
      w_lvlNegNext[i*LW +: LW] = L_FULL - w_lvlPosNext[i*LW +: LW];
      w_clkposNext[i]          = w_lvlPosNext[i*LW +: LW] > L_HALF;
    end
  end

  assign w_syncNext = (w_stateNext == ST_RUN) && (w_sNext == '0) &&
                      (w_kNext == '0) && (w_mNext == 2'd0);
  assign w_busyNext = (|w_armedNext) || (w_stateNext == ST_RUN);

  // State and timebase registers; reset drops everything back to STOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_STOP;
      r_s     <= '0;
      r_k     <= '0;
      r_m     <= '0;
      r_armed <= '0;
    end else begin
      r_state <= w_stateNext;
      r_s     <= w_sNext;
      r_k     <= w_kNext;
      r_m     <= w_mNext;
      r_armed <= w_armedNext;
    end
  end

  // Output registers; reset snaps the rails to empty/full at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvlPos <= '0;
      r_lvlNeg <= {4{L_FULL}};
      r_clkpos <= '0;
      r_sync   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_lvlPos <= w_lvlPosNext;
      r_lvlNeg <= w_lvlNegNext;
      r_clkpos <= w_clkposNext;
      r_sync   <= w_syncNext;
      r_busy   <= w_busyNext;
    end
  end

  assign bus.lvl_pos = r_lvlPos;
  assign bus.lvl_neg = r_lvlNeg;
  assign bus.clkpos  = r_clkpos;
  assign bus.clkneg  = ~r_clkpos;
  assign bus.sync    = r_sync;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_adiabatic_pclk_gen.sv
// ---------------------------------------------------------------------------
// tb_adiabatic_pclk_gen
// Bench for the four-phase adiabatic power-clock generator with STEPS=4,
// STEP_CYC=2 (interval 8 cycles, period 32). A trapezoid-position model
// predicts every output cycle; hand-written sequences cover start-up,
// drain, restart during drain and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_adiabatic_pclk_gen;

  localparam int STEPS    = 4;
  localparam int STEP_CYC = 2;
  localparam int LW       = 3;
  localparam int IV       = STEPS * STEP_CYC;
  localparam int PER      = 4 * IV;

  logic clk = 1'b0;
  logic rst_n;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  adiabatic_pclk_gen_if #(.LW(LW)) bus ();

  adiabatic_pclk_gen #(
    .STEPS   (STEPS),
    .STEP_CYC(STEP_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [4*LW-1:0] lvlPos;
    logic [4*LW-1:0] lvlNeg;
    logic [3:0]      clkpos;
    logic [3:0]      clkneg;
    logic            sync;
    logic            busy;
  } outRec_t;

  typedef struct {
    bit en;
    int lvl0;
    int lvl1;
    bit sync;
  } vec_t;

  outRec_t expQ[$];
  vec_t    vecs[24];

  int nVec  = 0;
  int nMiss = 0;

  // Model state: mode 0=stop 1=run 2=drain, position within the period,
  // and per-phase position within its trapezoid (-1 when not armed).
  int mMode;
  int mC;
  int mPos[4];

  logic [4*LW-1:0] prevPos;
  bit              prevValid;

  function automatic int modelLevel(input int pos);
    if (pos < 0)      return 0;
    if (pos < IV)     return pos / STEP_CYC + 1;
    if (pos < 2 * IV) return STEPS;
    return STEPS - 1 - (pos - 2 * IV) / STEP_CYC;
  endfunction

  task automatic modelReset();
    mMode = 0;
    mC    = 0;
    for (int i = 0; i < 4; i++) mPos[i] = -1;
    expQ.delete();
    prevValid = 1'b0;
  endtask

  task automatic modelStep(input bit enVal);
    int nm;
    bit anyArmed;
    if (mMode == 0) begin
      if (enVal) begin
        mMode   = 1;
        mC      = 0;
        mPos[0] = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (mPos[i] == 3 * IV - 1) mPos[i] = -1;
        else if (mPos[i] >= 0)     mPos[i] = mPos[i] + 1;
      end
      nm = mMode;
      if (mMode == 1 && mC == PER - 1 && !enVal) nm = 2;
      anyArmed = 1'b0;
      for (int i = 0; i < 4; i++) if (mPos[i] >= 0) anyArmed = 1'b1;
      if (mMode == 2 && !anyArmed) nm = 0;
      mMode = nm;
      mC    = (nm == 0) ? 0 : (mC + 1) % PER;
      if (nm == 1) begin
        for (int i = 0; i < 4; i++) if (mC == i * IV) mPos[i] = 0;
      end
    end
  endtask

  function automatic outRec_t modelOut();
    outRec_t r;
    int      lv;
    r.busy = (mMode == 1);
    for (int i = 0; i < 4; i++) begin
      lv = modelLevel(mPos[i]);
      r.lvlPos[i*LW +: LW] = LW'(lv);
      r.lvlNeg[i*LW +: LW] = LW'(STEPS - lv);
      r.clkpos[i]          = (lv > STEPS / 2);
      r.clkneg[i]          = !(lv > STEPS / 2);
      if (mPos[i] >= 0) r.busy = 1'b1;
    end
    r.sync = (mMode == 1) && (mC == 0);
    return r;
  endfunction

  task automatic checkDirect(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Pops the prediction for this cycle and compares the whole output bundle,
  // then checks that no rail moved by more than one level.
  task automatic checkOutput(input string tag);
    outRec_t e;
    bit      jump;
    int      a;
    int      b;
    nVec++;
    if (expQ.size() == 0) begin
      nMiss++;
      $display("[TB] FAIL %s scoreboard empty at %0t", tag, $time);
      return;
    end
    e = expQ.pop_front();
    if (bus.lvl_pos !== e.lvlPos || bus.lvl_neg !== e.lvlNeg ||
        bus.clkpos !== e.clkpos || bus.clkneg !== e.clkneg ||
        bus.sync !== e.sync || bus.busy !== e.busy) begin
      nMiss++;
      $display("[TB] FAIL %s at %0t: got pos=%h neg=%h cp=%b cn=%b sync=%b busy=%b, want pos=%h neg=%h cp=%b cn=%b sync=%b busy=%b",
               tag, $time, bus.lvl_pos, bus.lvl_neg, bus.clkpos, bus.clkneg,
               bus.sync, bus.busy, e.lvlPos, e.lvlNeg, e.clkpos, e.clkneg,
               e.sync, e.busy);
    end
    if (prevValid) begin
      nVec++;
      jump = 1'b0;
      for (int i = 0; i < 4; i++) begin
        a = int'(bus.lvl_pos[i*LW +: LW]);
        b = int'(prevPos[i*LW +: LW]);
        if (a - b > 1 || b - a > 1) jump = 1'b1;
      end
      if (jump) begin
        nMiss++;
        $display("[TB] FAIL %s rail step at %0t: got %h after %h, want change <=1",
                 tag, $time, bus.lvl_pos, prevPos);
      end
    end
    prevPos   = bus.lvl_pos;
    prevValid = 1'b1;
  endtask

  // One clock of stimulus: drive en on the falling edge, predict, then sample
  // just after the rising edge.
  task automatic applyStimulus(input bit enVal, input string tag);
    @(negedge clk);
    bus.en = enVal;
    modelStep(enVal);
    expQ.push_back(modelOut());
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkDirect({tag, " lvl_pos"}, 32'(bus.lvl_pos), 32'h000);
    checkDirect({tag, " lvl_neg"}, 32'(bus.lvl_neg), 32'h924);
    checkDirect({tag, " clkpos"},  32'(bus.clkpos),  32'h0);
    checkDirect({tag, " clkneg"},  32'(bus.clkneg),  32'hF);
    checkDirect({tag, " sync"},    32'(bus.sync),    32'h0);
    checkDirect({tag, " busy"},    32'(bus.busy),    32'h0);
  endtask

  // Hard stop in case something stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  // Main test sequence.
  initial begin
    int lvl0Tab[24];
    int lvl1Tab[24];
    int stopSeen;
    bit restarted;

    lvl0Tab = '{1,1,2,2,3,3,4,4, 4,4,4,4,4,4,4,4, 3,3,2,2,1,1,0,0};
    lvl1Tab = '{0,0,0,0,0,0,0,0, 1,1,2,2,3,3,4,4, 4,4,4,4,4,4,4,4};
    for (int i = 0; i < 24; i++) begin
      vecs[i].en   = !(i >= 10 && i <= 12);
      vecs[i].lvl0 = lvl0Tab[i];
      vecs[i].lvl1 = lvl1Tab[i];
      vecs[i].sync = (i == 0);
    end

    rst_n  = 1'b0;
    bus.en = 1'b1;
    modelReset();

    // Reset held with en=1: rails stay at reset values.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checkResetOutputs("reset-held");
    end
    rst_n = 1'b1;

    // First period from the table, with a mid-period en dip that must not matter.
    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].en, "period1");
      checkDirect("period1 phase0", 32'(bus.lvl_pos[2:0]), 32'(vecs[i].lvl0));
      checkDirect("period1 phase1", 32'(bus.lvl_pos[5:3]), 32'(vecs[i].lvl1));
      checkDirect("period1 sync",   32'(bus.sync),         32'(vecs[i].sync));
    end

    for (int c = 24; c < 40; c++) applyStimulus(1'b1, "steady");

    // en drops mid-period; the run finishes its period, then drains.
    for (int c = 40; c < 88; c++) begin
      applyStimulus(1'b0, "drain");
      if (c == 63) checkDirect("drain busy@63", 32'(bus.busy), 32'h1);
      if (c == 64) checkDirect("drain no new UP", 32'(bus.lvl_pos[2:0]), 32'h0);
      if (c == 79) checkDirect("drain phase3 end", 32'(bus.lvl_pos[11:9]), 32'h0);
      if (c == 80) checkDirect("drain busy@80", 32'(bus.busy), 32'h0);
    end

    // Restart, then re-raise en while draining.
    for (int c = 0; c < 32; c++) applyStimulus(1'b1, "run2");
    applyStimulus(1'b0, "run2-stop");
    stopSeen  = 0;
    restarted = 1'b0;
    for (int c = 0; c < 40 && !restarted; c++) begin
      applyStimulus(1'b1, "drain-reraise");
      if (bus.busy === 1'b0) stopSeen++;
      if (bus.sync === 1'b1) restarted = 1'b1;
    end
    checkDirect("restart sync", 32'(restarted), 32'h1);
    checkDirect("stop cycles before restart", 32'(stopSeen), 32'h1);

    // Into phase0 HOLD, then pull reset asynchronously.
    for (int c = 0; c < 10; c++) applyStimulus(1'b1, "run3");
    checkDirect("phase0 hold", 32'(bus.lvl_pos[2:0]), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("async reset");
    modelReset();
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, "post-reset stop");
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, "post-reset run");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
